// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the fifo stream reader
package fifo_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } rd_state_e;

   // One output-buffer entry at the default data width: payload plus its burst-end tag
   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic                  last;
   } buf_entry_t;

   // A word closes the burst when its index reaches len-1; len==0 means untagged stream
   function automatic logic burst_is_last(input logic [7:0] idx, input logic [7:0] len);
      return (len != 8'd0) && (idx == (len - 8'd1));
   endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - small in-order output buffer with push/pop and occupancy
module fifo_skid_buf #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 2,
   localparam int OCC_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [OCC_W-1:0] occ
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   // A full buffer still takes a push when the head leaves in the same cycle
   assign do_pop  = pop && (occ != '0);
   assign do_push = push && ((occ < OCC_W'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage, pointers and occupancy; entries are zeroed on reset so head reads 0
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (do_push && !do_pop) begin
            occ <= occ + 1'b1;
         end else if (!do_push && do_pop) begin
            occ <= occ - 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - fifo read master re-presenting words as a burst-tagged stream
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int SKID_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [7:0]        cfg_burst_len,
   input  logic [DATA_W-1:0] fifo_data_out,
   input  logic              fifo_read_valid,
   input  logic              fifo_empty,
   output logic              fifo_read_en,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  word_count,
   output logic              err_unexp
);

   localparam int OCC_W = $clog2(SKID_DEPTH + 1);
   localparam int ENT_W = DATA_W + 1;

   rd_state_e        state;
   logic             inflight;
   logic [7:0]       burst_len_q;
   logic [7:0]       burst_idx;
   logic [OCC_W-1:0] occ;
   logic [ENT_W-1:0] head;
   logic             pop;
   logic             push;
   logic             push_last;
   logic [OCC_W:0]   credit_used;

   assign pop       = m_valid & m_ready;
   assign push      = fifo_read_valid & inflight;
   assign push_last = burst_is_last(burst_idx, burst_len_q);

   assign m_valid = (occ != '0);
   assign m_data  = head[ENT_W-1:1];
   assign m_last  = head[0];

   // Slots already claimed after this cycle's pop, counting the read still in flight
   assign credit_used  = {1'b0, occ} - {{OCC_W{1'b0}}, pop} + {{OCC_W{1'b0}}, inflight};
   assign fifo_read_en = (state == RUN) && !fifo_empty &&
                         (credit_used < (OCC_W + 1)'(SKID_DEPTH));

   fifo_skid_buf #(
      .WIDTH (ENT_W),
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({fifo_data_out, push_last}),
      .pop       (pop),
      .head      (head),
      .occ       (occ)
   );

   // Control FSM plus burst position tracking; burst length relatches only at a burst boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         burst_len_q <= 8'd0;
         burst_idx   <= 8'd0;
      end else begin
         if (push) begin
            if (push_last) begin
               burst_idx   <= 8'd0;
               burst_len_q <= cfg_burst_len;
            end else if (burst_len_q == 8'd0) begin
               burst_idx <= 8'd0;
            end else begin
               burst_idx <= burst_idx + 8'd1;
            end
         end
         case (state)
            IDLE: begin
               if (enable) begin
                  state       <= RUN;
                  busy        <= 1'b1;
                  burst_len_q <= cfg_burst_len;
                  burst_idx   <= 8'd0;
               end
            end
            RUN: begin
               if (!enable) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               if (enable) begin
                  state <= RUN;
               end else if (!inflight && (occ == '0)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Outstanding-read flag, sticky stray-data flag and delivered-word counter
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight   <= 1'b0;
         err_unexp  <= 1'b0;
         word_count <= '0;
      end else begin
         if (fifo_read_en) begin
            inflight <= 1'b1;
         end else if (fifo_read_valid) begin
            inflight <= 1'b0;
         end
         if (fifo_read_valid && !inflight) begin
            err_unexp <= 1'b1;
         end
         if (pop) begin
            word_count <= word_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [7:0]  cfg_burst_len;
   logic [7:0]  fifo_data_out;
   logic        fifo_read_valid;
   logic        fifo_empty;
   logic        fifo_read_en;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_last;
   logic        m_ready;
   logic        busy;
   logic [15:0] word_count;
   logic        err_unexp;

   always #5 clk = ~clk;

   fifo_stream_reader #(
      .DATA_W     (8),
      .SKID_DEPTH (2),
      .CNT_W      (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .cfg_burst_len   (cfg_burst_len),
      .fifo_data_out   (fifo_data_out),
      .fifo_read_valid (fifo_read_valid),
      .fifo_empty      (fifo_empty),
      .fifo_read_en    (fifo_read_en),
      .m_data          (m_data),
      .m_valid         (m_valid),
      .m_last          (m_last),
      .m_ready         (m_ready),
      .busy            (busy),
      .word_count      (word_count),
      .err_unexp       (err_unexp)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] mem[$];
   logic [8:0] obs[$];
   int         obs_cyc[$];
   int         cyc = 0;
   int         reads = 0;
   int         empty_reads = 0;
   int         first_re = -1;
   int         first_v = -1;
   int         held_changes = 0;
   logic [7:0] held_data = 8'h00;
   logic       held_ok = 1'b0;
   int         r0;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // One clock: sample before the edge, then play the fifo (1-clk read latency) after it
   task automatic step();
      logic re;
      #3;
      re = fifo_read_en;
      if (re) begin
         reads++;
         if (fifo_empty) empty_reads++;
         if (first_re < 0) first_re = cyc;
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
         obs.push_back({m_data, m_last});
         obs_cyc.push_back(cyc);
      end
      if (m_valid && !m_ready) begin
         if (held_ok && m_data !== held_data) held_changes++;
         held_data = m_data;
         held_ok   = 1'b1;
      end else begin
         held_ok = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (re && mem.size() > 0) begin
         fifo_read_valid = 1'b1;
         fifo_data_out   = mem.pop_front();
      end else begin
         fifo_read_valid = 1'b0;
      end
      fifo_empty = (mem.size() == 0);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic load(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) mem.push_back(base + 8'(i));
      fifo_empty = (mem.size() == 0);
   endtask

   function automatic logic [8:0] obs_at(input int i);
      return (i < obs.size()) ? obs[i] : 9'h1ff;
   endfunction

   initial begin
      rst             = 1'b1;
      enable          = 1'b0;
      cfg_burst_len   = 8'd0;
      fifo_data_out   = 8'h00;
      fifo_read_valid = 1'b0;
      fifo_empty      = 1'b1;
      m_ready         = 1'b0;
      @(posedge clk);
      #1;
      run(2);

      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_word_count", word_count, 0);
      chk("rst_err", err_unexp, 0);
      chk("rst_read_en", fifo_read_en, 0);
      rst = 1'b0;
      run(1);

      // continuous stream of 0..4
      load(5, 8'h00);
      enable  = 1'b1;
      m_ready = 1'b1;
      run(12);
      chk("t1_count", obs.size(), 5);
      for (int i = 0; i < 5; i++) chk("t1_word", obs_at(i), {8'(i), 1'b0});
      chk("t1_back_to_back", (obs_cyc.size() == 5) ? obs_cyc[4] - obs_cyc[0] : -1, 4);
      chk("t1_latency", first_v - first_re, 2);
      chk("t1_word_count", word_count, 5);
      enable = 1'b0;
      run(4);
      chk("t1_idle", busy, 0);

      // bursts of 4 over 10 words
      obs.delete();
      obs_cyc.delete();
      load(10, 8'h10);
      cfg_burst_len = 8'd4;
      enable        = 1'b1;
      run(16);
      chk("t2_count", obs.size(), 10);
      for (int i = 0; i < 10; i++)
         chk("t2_word", obs_at(i), {8'h10 + 8'(i), (i == 3 || i == 7)});
      chk("t2_burst_idx", dut.burst_idx, 2);
      chk("t2_word_count", word_count, 15);
      enable = 1'b0;
      run(4);

      // backpressure for 8 clocks
      obs.delete();
      obs_cyc.delete();
      held_changes  = 0;
      cfg_burst_len = 8'd0;
      m_ready       = 1'b0;
      load(8, 8'h20);
      enable = 1'b1;
      r0     = reads;
      run(8);
      chk("t3_reads_bounded", reads - r0, 2);
      chk("t3_m_valid", m_valid, 1);
      chk("t3_head", m_data, 8'h20);
      chk("t3_held_stable", held_changes, 0);
      m_ready = 1'b1;
      run(14);
      chk("t3_count", obs.size(), 8);
      for (int i = 0; i < 8; i++) chk("t3_word", obs_at(i), {8'h20 + 8'(i), 1'b0});
      chk("t3_word_count", word_count, 23);
      enable = 1'b0;
      run(4);

      // enable drop with one read in flight and one word buffered
      obs.delete();
      obs_cyc.delete();
      m_ready = 1'b0;
      load(6, 8'h30);
      enable = 1'b1;
      run(3);
      enable = 1'b0;
      r0     = reads;
      run(1);
      chk("t4_no_read", reads - r0, 0);
      chk("t4_buffered", m_valid, 1);
      chk("t4_busy_flush", busy, 1);
      m_ready = 1'b1;
      run(2);
      chk("t4_count", obs.size(), 2);
      chk("t4_word0", obs_at(0), {8'h30, 1'b0});
      chk("t4_word1", obs_at(1), {8'h31, 1'b0});
      chk("t4_busy_drain", busy, 1);
      run(1);
      chk("t4_busy_low", busy, 0);
      chk("t4_no_read_total", reads - r0, 0);
      chk("t4_word_count", word_count, 25);
      mem.delete();
      fifo_empty = 1'b1;
      run(1);

      // stray read-valid with nothing requested
      fifo_read_valid = 1'b1;
      fifo_data_out   = 8'hAA;
      step();
      chk("t5_err_set", err_unexp, 1);
      chk("t5_no_data", m_valid, 0);
      run(3);
      chk("t5_err_sticky", err_unexp, 1);
      chk("t5_still_empty", m_valid, 0);
      chk("t5_word_count", word_count, 25);

      // reset with a full buffer mid-burst
      m_ready       = 1'b0;
      cfg_burst_len = 8'd4;
      load(8, 8'h40);
      enable = 1'b1;
      run(6);
      chk("t6_full_valid", m_valid, 1);
      chk("t6_full_head", m_data, 8'h40);
      rst = 1'b1;
      step();
      chk("t6_m_valid", m_valid, 0);
      chk("t6_m_last", m_last, 0);
      chk("t6_m_data", m_data, 0);
      chk("t6_busy", busy, 0);
      chk("t6_word_count", word_count, 0);
      chk("t6_err", err_unexp, 0);
      chk("t6_read_en", fifo_read_en, 0);
      rst    = 1'b0;
      enable = 1'b0;
      run(2);
      chk("t6_discarded", m_valid, 0);
      chk("t6_err_clear", err_unexp, 0);

      chk("never_read_empty", empty_reads, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
